mcpu_clkrst_seq: RTL and testbench



---
 rtl/mcpu_clkrst_pkg.sv | 21 ++
 rtl/mcpu_sync2.sv | 27 ++
 rtl/mcpu_clkrst_seq.sv | 143 ++++++++++++++
 tb/tb_mcpu_clkrst_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mcpu_clkrst_pkg.sv
// Shared state encoding and default timing constants for the MCPU reset sequencer.
package mcpu_clkrst_pkg;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t StWaitLock = 3'd0;
    localparam seq_state_t StMemRst   = 3'd1;
    localparam seq_state_t StWaitMc   = 3'd2;
    localparam seq_state_t StCoreRst  = 3'd3;
    localparam seq_state_t StRun      = 3'd4;

    localparam int unsigned DefMemRstCycles  = 16;
    localparam int unsigned DefCoreRstCycles = 16;
    localparam int unsigned DefMcTimeout     = 1048576;

    // Width of a down/up counter that must hold n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/mcpu_sync2.sv
// Two-flop synchronizer with a parameterised asynchronous reset value.
module mcpu_sync2 #(
    parameter logic RstVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], d_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {2{RstVal}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/mcpu_clkrst_seq.sv
// Reset sequencer: turns board reset and PLL lock into ordered, stretched
// memory-domain and core-domain resets, releasing memory before core.
module mcpu_clkrst_seq
    import mcpu_clkrst_pkg::*;
#(
    parameter int unsigned MEM_RST_CYCLES  = DefMemRstCycles,
    parameter int unsigned CORE_RST_CYCLES = DefCoreRstCycles,
    parameter int unsigned MC_TIMEOUT      = DefMcTimeout
) (
    input  logic       clkrst_core_clk,
    input  logic       in_rst_n,
    input  logic       pll_locked,
    input  logic       mc_ready,
    input  logic       soft_rst_req,
    output logic       clkrst_mem_rst_n,
    output logic       clkrst_core_rst_n,
    output logic [2:0] seq_state,
    output logic       seq_timeout
);

    localparam int unsigned MemW = cnt_width(MEM_RST_CYCLES);
    localparam int unsigned CoreW = cnt_width(CORE_RST_CYCLES);
    localparam int unsigned CntW = (MemW > CoreW) ? MemW : CoreW;
    localparam int unsigned TmoW = cnt_width(MC_TIMEOUT);

    localparam logic [CntW-1:0] MemLoad  = CntW'(MEM_RST_CYCLES - 1);
    localparam logic [CntW-1:0] CoreLoad = CntW'(CORE_RST_CYCLES - 1);
    localparam logic [TmoW-1:0] TmoLast  = TmoW'(MC_TIMEOUT - 1);

    logic            rst_sync_n;
    logic            lock_s;
    seq_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            timeout_q, timeout_d;
    logic            mem_rst_n_q, mem_rst_n_d;
    logic            core_rst_n_q, core_rst_n_d;

    mcpu_sync2 #(
        .RstVal (1'b0)
    ) u_rst_sync (
        .clk_i  (clkrst_core_clk),
        .rst_ni (in_rst_n),
        .d_i    (1'b1),
        .q_o    (rst_sync_n)
    );

    mcpu_sync2 #(
        .RstVal (1'b0)
    ) u_lock_sync (
        .clk_i  (clkrst_core_clk),
        .rst_ni (rst_sync_n),
        .d_i    (pll_locked),
        .q_o    (lock_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = timeout_q;

        case (state_q)
            StWaitLock: begin
                if (lock_s) begin
                    state_d = StMemRst;
                    cnt_d   = MemLoad;
                end
            end
            StMemRst: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d   = StWaitMc;
                    tmo_cnt_d = '0;
                end
            end
            StWaitMc: begin
                // A ready controller takes precedence over a coincident timeout.
                if (mc_ready) begin
                    state_d = StCoreRst;
                    cnt_d   = CoreLoad;
                end else if (tmo_cnt_q == TmoLast) begin
                    state_d   = StCoreRst;
                    cnt_d     = CoreLoad;
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
            end
            StCoreRst: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (soft_rst_req) begin
                    state_d = StCoreRst;
                    cnt_d   = CoreLoad;
                end
            end
            default: begin
                state_d = StWaitLock;
            end
        endcase

        // Losing lock overrides every other transition, including a timeout flag update.
        if (!lock_s && (state_q != StWaitLock)) begin
            state_d   = StWaitLock;
            cnt_d     = '0;
            timeout_d = timeout_q;
        end

        mem_rst_n_d  = (state_d == StWaitMc) || (state_d == StCoreRst) || (state_d == StRun);
        core_rst_n_d = (state_d == StRun);
    end

    always_ff @(posedge clkrst_core_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q      <= StWaitLock;
            cnt_q        <= '0;
            tmo_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            mem_rst_n_q  <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            timeout_q    <= timeout_d;
            mem_rst_n_q  <= mem_rst_n_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign clkrst_mem_rst_n  = mem_rst_n_q;
    assign clkrst_core_rst_n = core_rst_n_q;
    assign seq_state         = state_q;
    assign seq_timeout       = timeout_q;

endmodule

// File: tb/tb_mcpu_clkrst_seq.sv
// Bench for the reset sequencer: expected waveforms come from edge arithmetic on the
// documented hold times, timeout limit and synchronizer latencies.
module tb_mcpu_clkrst_seq;

    localparam int MemCyc  = 16;
    localparam int CoreCyc = 16;
    localparam int Tmo     = 64;

    logic       clk = 1'b0;
    logic       in_rst_n;
    logic       pll_locked;
    logic       mc_ready;
    logic       soft_rst_req;
    logic       mem_rst_n;
    logic       core_rst_n;
    logic [2:0] seq_state;
    logic       seq_timeout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic tmo_exp = 1'b0;

    mcpu_clkrst_seq #(
        .MEM_RST_CYCLES  (MemCyc),
        .CORE_RST_CYCLES (CoreCyc),
        .MC_TIMEOUT      (Tmo)
    ) dut (
        .clkrst_core_clk   (clk),
        .in_rst_n          (in_rst_n),
        .pll_locked        (pll_locked),
        .mc_ready          (mc_ready),
        .soft_rst_req      (soft_rst_req),
        .clkrst_mem_rst_n  (mem_rst_n),
        .clkrst_core_rst_n (core_rst_n),
        .seq_state         (seq_state),
        .seq_timeout       (seq_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all(input logic [2:0] st, input logic mem, input logic core,
                           input logic tmo);
        chk("seq_state", {29'b0, seq_state}, {29'b0, st});
        chk("mem_rst_n", {31'b0, mem_rst_n}, {31'b0, mem});
        chk("core_rst_n", {31'b0, core_rst_n}, {31'b0, core});
        chk("seq_timeout", {31'b0, seq_timeout}, {31'b0, tmo});
    endtask

    // e0: edge that enters the memory-reset phase; mc_ready is high from relative edge r on.
    task automatic check_seq(input int e0, input int r);
        int jm;
        int x;
        logic hit;
        jm  = (r > MemCyc + 1) ? r - (MemCyc + 1) : 0;
        x   = MemCyc + 1 + ((jm < Tmo - 1) ? jm : Tmo - 1);
        hit = (jm > Tmo - 1);
        while (cyc - e0 < x + CoreCyc + 2) begin
            int en;
            int e;
            logic [2:0] st;
            en = cyc + 1 - e0;
            mc_ready = (en >= r);
            // Requests are scattered wherever the sequencer is not yet in RUN.
            soft_rst_req = (en <= x + CoreCyc) && ($urandom_range(0, 3) == 0);
            step();
            e = cyc - e0;
            if (e == x && hit) tmo_exp = 1'b1;
            if (e < 0) st = 3'd0;
            else if (e < MemCyc) st = 3'd1;
            else if (e < x) st = 3'd2;
            else if (e < x + CoreCyc) st = 3'd3;
            else st = 3'd4;
            chk_all(st, e >= MemCyc, e >= x + CoreCyc, tmo_exp);
        end
        soft_rst_req = 1'b0;
    endtask

    // From RUN: one request, plus a second one at relative edge 'second' that must be ignored.
    task automatic soft_check(input int second);
        for (int k = 0; k <= CoreCyc + 1; k++) begin
            soft_rst_req = (k == 0) || (k == second);
            step();
            chk_all((k < CoreCyc) ? 3'd3 : 3'd4, 1'b1, k >= CoreCyc, tmo_exp);
        end
        soft_rst_req = 1'b0;
    endtask

    // From RUN: drop the PLL; both resets assert together after the lock synchronizer delay.
    task automatic lock_drop();
        pll_locked = 1'b0;
        mc_ready   = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k < 3) chk_all(3'd4, 1'b1, 1'b1, tmo_exp);
            else chk_all(3'd0, 1'b0, 1'b0, tmo_exp);
        end
    endtask

    initial begin
        int e0;
        in_rst_n     = 1'b0;
        pll_locked   = 1'b1;
        mc_ready     = 1'b1;
        soft_rst_req = 1'b0;

        // Power-up
        for (int k = 0; k < 5; k++) begin
            step();
            chk_all(3'd0, 1'b0, 1'b0, 1'b0);
        end
        in_rst_n = 1'b1;
        check_seq(cyc + 5, 0);

        // Soft reset from RUN with an ignored second request
        soft_check(int'($urandom_range(1, CoreCyc)));

        // Replays after lock loss: mc_ready exactly at the timeout edge, then one edge late
        lock_drop();
        pll_locked = 1'b1;
        check_seq(cyc + 3, MemCyc + Tmo);
        lock_drop();
        pll_locked = 1'b1;
        check_seq(cyc + 3, MemCyc + 1 + Tmo);
        for (int i = 0; i < 3; i++) begin
            lock_drop();
            pll_locked = 1'b1;
            check_seq(cyc + 3, int'($urandom_range(0, 100)));
        end

        // Timeout flag survives a soft reset
        soft_check(int'($urandom_range(1, CoreCyc)));

        // Board reset while the memory counter holds 7
        lock_drop();
        pll_locked = 1'b1;
        e0 = cyc + 3;
        while (cyc < e0 + 8) begin
            step();
            chk_all((cyc < e0) ? 3'd0 : 3'd1, 1'b0, 1'b0, tmo_exp);
        end
        #2;
        in_rst_n = 1'b0;
        tmo_exp  = 1'b0;
        #1;
        chk_all(3'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all(3'd0, 1'b0, 1'b0, 1'b0);
        end
        in_rst_n = 1'b1;
        check_seq(cyc + 5, int'($urandom_range(0, 100)));

        // Late PLL lock after reset release
        in_rst_n   = 1'b0;
        pll_locked = 1'b0;
        tmo_exp    = 1'b0;
        step();
        in_rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            chk_all(3'd0, 1'b0, 1'b0, 1'b0);
        end
        pll_locked = 1'b1;
        check_seq(cyc + 3, int'($urandom_range(0, 100)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
